// File: rtl/balance_digit_scanner_if.sv
// ---------------------------------------------------------------------------
// balance_digit_scanner_if
// Bundles the request side (start, balance, blank_lz) and the display side
// (data, digit_sel, busy, done, overflow) of the balance digit scanner.
//   master : drives start/balance/blank_lz, observes the display outputs
//   slave  : the scanner itself
// ---------------------------------------------------------------------------
interface balance_digit_scanner_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic              start;
  logic [WIDTH-1:0]  balance;
  logic              blank_lz;
  logic [7:0]        data;
  logic [DIGITS-1:0] digit_sel;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output start, balance, blank_lz,
    input  data, digit_sel, busy, done, overflow
  );

  modport slave (
    input  start, balance, blank_lz,
    output data, digit_sel, busy, done, overflow
  );
endinterface

// File: rtl/balance_digit_scanner.sv
// ---------------------------------------------------------------------------
// balance_digit_scanner
// Converts a binary balance to BCD with shift-add-3 (one bit per cycle) and
// time-multiplexes the committed digits onto the seven-segment decoder input.
// Ports:
//   i_clk      system clock, rising edge
//   i_reset    synchronous, active-high reset
//   bus.start      one-cycle convert request (honoured in IDLE only)
//   bus.balance    unsigned binary balance
//   bus.blank_lz   blank leading zeros (digit 0 never blanked)
//   bus.data       decoder code {4'h0, bcd} or 8'h0F for a blank digit
//   bus.digit_sel  one-hot digit enable, bit 0 = units
//   bus.busy       conversion in progress
//   bus.done       one-cycle pulse when new digits are committed
//   bus.overflow   displayed value came from a balance above 9999
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; display shows last committed value
// S_SHIFT  | one add-3/shift iteration per cycle, WIDTH iterations
// S_COMMIT | new digits visible, done pulses, back to IDLE
// ---------------------------------------------------------------------------
module balance_digit_scanner #(
  parameter int WIDTH    = 14,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  balance_digit_scanner_if.slave bus
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(WIDTH);
  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(9999);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [WIDTH-1:0]        r_bin;
  logic [BCD_W-1:0]        r_bcd;
  logic [ITER_W-1:0]       r_iter;
  logic                    r_ovf_pend;
  logic [BCD_W-1:0]        r_digits;
  logic                    r_overflow;
  logic [CNT_W-1:0]        r_scan_cnt;
  logic [IDX_W-1:0]        r_scan_idx;
  logic [DIGITS-1:0]       r_digit_sel;
  logic [7:0]              r_data;

  logic                    w_capture;
  logic                    w_busy;
  logic                    w_done;
  logic                    w_last_iter;
  logic [BCD_W-1:0]        w_bcd_adj;
  logic [BCD_W+WIDTH-1:0]  w_shifted;
  logic [BCD_W-1:0]        w_bcd_next;
  logic [DIGITS-1:0]       w_zero_from;
  logic [3:0]              w_cur_nib;
  logic                    w_blank;
  logic [7:0]              w_code;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_capture    = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (w_last_iter) w_state_next = S_COMMIT;
      end
      S_COMMIT: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- double dabble datapath ----------------
  assign w_last_iter = (r_iter == ITER_W'(WIDTH - 1));

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  assign w_shifted  = {w_bcd_adj, r_bin} << 1;
  assign w_bcd_next = w_shifted[BCD_W+WIDTH-1 -: BCD_W];

  // Digits are written on the edge that enters COMMIT so they are already
  // visible in the same cycle that done is high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_iter     <= '0;
      r_ovf_pend <= 1'b0;
      r_digits   <= '0;
      r_overflow <= 1'b0;
    end else if (w_capture) begin
      r_bin      <= bus.balance;
      r_bcd      <= '0;
      r_iter     <= '0;
      r_ovf_pend <= (bus.balance > MAX_VAL);
    end else if (r_state == S_SHIFT) begin
      r_bcd  <= w_bcd_next;
      r_bin  <= w_shifted[WIDTH-1:0];
      r_iter <= r_iter + 1'b1;
      if (w_last_iter) begin
        r_digits   <= r_ovf_pend ? '1 : w_bcd_next;
        r_overflow <= r_ovf_pend;
      end
    end
  end

  // ---------------- display scan ----------------
  // w_zero_from[k]: digit k and every digit above it are zero.
  always_comb begin
    logic zero_run;
    zero_run    = 1'b1;
    w_zero_from = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run       = zero_run && (r_digits[4*k +: 4] == 4'd0);
      w_zero_from[k] = zero_run;
    end
  end

  // Overflow digits are 4'hF, never zero, so blanking cannot touch them.
  assign w_cur_nib = r_digits[4*r_scan_idx +: 4];
  assign w_blank   = bus.blank_lz && (r_scan_idx != '0) && w_zero_from[r_scan_idx];
  assign w_code    = w_blank ? 8'h0F : {4'h0, w_cur_nib};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scan_cnt  <= '0;
      r_scan_idx  <= '0;
      r_digit_sel <= DIGITS'(1);
      r_data      <= 8'h00;
    end else begin
      if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_scan_idx <= (r_scan_idx == IDX_W'(DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      r_digit_sel <= DIGITS'(1) << r_scan_idx;
      r_data      <= w_code;
    end
  end

  assign bus.data      = r_data;
  assign bus.digit_sel = r_digit_sel;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_balance_digit_scanner.sv
`timescale 1ns/1ps
module tb_balance_digit_scanner;
  localparam int WIDTH    = 14;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // codes/codes_lz packed as {d3, d2, d1, d0}, one decoder byte per digit
  typedef struct {
    logic [31:0] codes;
    logic [31:0] codes_lz;
    logic        ovf;
    int          done_cyc;
  } exp_t;
  exp_t sb[$];

  balance_digit_scanner_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  balance_digit_scanner #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] disp     = 32'h0;
  logic [31:0] disp_lz  = 32'h0;
  logic        ovf_m    = 1'b0;
  logic        lz_q     = 1'b0;
  logic        rst_q    = 1'b1;
  logic [3:0]  sel_q    = 4'b0001;
  int          hold     = 0;
  bit          hold_ok  = 1'b0;
  int          busy_run = 0;

  always @(negedge clk) begin
    int   idx;
    exp_t e;
    if (rst_q) begin
      check("reset_outputs",
            32'({bus.data, bus.digit_sel, bus.busy, bus.done, bus.overflow}),
            32'({8'h00, 4'b0001, 3'b000}));
      disp = 32'h0; disp_lz = 32'h0; ovf_m = 1'b0;
      hold = 0; hold_ok = 1'b0; busy_run = 0;
    end else begin
      check("digit_sel_onehot", 32'($onehot(bus.digit_sel)), 32'd1);
      case (bus.digit_sel)
        4'b0001: idx = 0;
        4'b0010: idx = 1;
        4'b0100: idx = 2;
        4'b1000: idx = 3;
        default: idx = -1;
      endcase
      if (idx >= 0)
        check($sformatf("display_d%0d", idx), 32'(bus.data),
              32'(lz_q ? disp_lz[8*idx +: 8] : disp[8*idx +: 8]));
      if (bus.digit_sel != sel_q) begin
        check("scan_order", 32'(bus.digit_sel), 32'({sel_q[2:0], sel_q[3]}));
        if (hold_ok) check("scan_hold", 32'(hold), 32'(SCAN_DIV));
        hold = 1; hold_ok = 1'b1;
      end else begin
        hold++;
      end
      if (bus.done) begin
        check("busy_length", 32'(busy_run), 32'(WIDTH));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done: done=1 with no conversion pending (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          disp = e.codes; disp_lz = e.codes_lz; ovf_m = e.ovf;
        end
      end
      busy_run = bus.busy ? busy_run + 1 : 0;
      check("overflow", 32'(bus.overflow), 32'(ovf_m));
    end
    lz_q  = bus.blank_lz;
    rst_q = reset;
    sel_q = bus.digit_sel;
  end

  // ---------------- stimulus ----------------
  task automatic convert(input int bal, input logic [31:0] codes,
                         input logic [31:0] codes_lz, input logic ovf);
    exp_t e;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.balance = WIDTH'(bal);
    e.codes = codes; e.codes_lz = codes_lz; e.ovf = ovf;
    e.done_cyc = cyc + 1 + WIDTH;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4 * WIDTH) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("done_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic show();
    repeat (4 * SCAN_DIV + 4) @(posedge clk);
    #1;
  endtask

  task automatic set_lz(input logic v);
    @(posedge clk); #1;
    bus.blank_lz = v;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.balance  = '0;
    bus.blank_lz = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    show();

    convert(1234, 32'h01020304, 32'h01020304, 1'b0); wait_done(); show();

    set_lz(1'b1);
    convert(0,    32'h00000000, 32'h0F0F0F00, 1'b0); wait_done(); show();
    convert(105,  32'h00010005, 32'h0F010005, 1'b0); wait_done(); show();
    set_lz(1'b0); show();

    convert(9999, 32'h09090909, 32'h09090909, 1'b0); wait_done(); show();
    set_lz(1'b1);
    convert(10000, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b1); wait_done(); show();
    convert(16383, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b1); wait_done();
    set_lz(1'b0);
    convert(42,   32'h00000402, 32'h0F0F0402, 1'b0); wait_done(); show();

    // second start five cycles into the conversion must be dropped
    @(posedge clk); #1;
    bus.start = 1'b1; bus.balance = WIDTH'(1234);
    begin
      exp_t e;
      e.codes = 32'h01020304; e.codes_lz = 32'h01020304; e.ovf = 1'b0;
      e.done_cyc = cyc + 1 + WIDTH;
      sb.push_back(e);
    end
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1; bus.start = 1'b1; bus.balance = WIDTH'(7777);
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(); show();

    // reset at the seventh shift cycle aborts the conversion
    @(posedge clk); #1;
    bus.start = 1'b1; bus.balance = WIDTH'(1234);
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (2 * WIDTH) @(posedge clk);
    #1;
    show();

    convert(500, 32'h00050000, 32'h0F050000, 1'b0); wait_done();
    set_lz(1'b1); show();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/balance_digit_scanner.md
Name: balance_digit_scanner

Overview:
- Upstream feeder for the bank system's seven-segment decoder.
- Converts a binary account balance into four BCD digits using iterative shift-add-3 (double dabble).
- Time-multiplexes the digits onto a single decoder input and drives one-hot digit enables.
- The `data` output connects directly to the decoder's 8-bit `data` input. Code 8'h0F blanks the digit, because the decoder's default case drives all segments off.

Parameters:
- WIDTH, 14, bit width of the binary balance input. Maximum displayable value is 9999.
- DIGITS, 4, number of display digits. Fixed at 4 for this revision.
- SCAN_DIV, 16, clock cycles each digit is held before the scan advances. Minimum 2.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to capture `balance` and convert it. Sampled only in IDLE.
- balance  input  WIDTH  unsigned binary balance to display.
- blank_lz  input  1  1 = blank leading zeros. Digit 0 is never blanked. Sampled continuously.
- data  output  8  digit code to the decoder: {4'b0000, bcd}, or 8'h0F when blanked.
- digit_sel  output  DIGITS  one-hot, active-high digit enable. Bit 0 = units digit.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the new digits are committed.
- overflow  output  1  high while the displayed value came from a balance > 9999.

Behaviour:
- Reset values (reset high at a clock edge):
  - data = 8'h00, digit_sel = 4'b0001, busy = 0, done = 0, overflow = 0.
  - Committed digit registers = 0; scan counter = 0; scan index = 0; state = IDLE.
- State machine:
  - IDLE: start = 1 → capture `balance` into the shift register, clear the BCD accumulator and iteration count, latch `ovf_pending = (balance > 9999)`, go to SHIFT.
  - SHIFT: busy = 1. Each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by one. After exactly WIDTH iterations, go to COMMIT.
  - COMMIT: busy = 0. Commit the BCD digits, or 4'hF in all digits if ovf_pending. Set overflow = ovf_pending. Pulse done = 1 for this cycle only. Return to IDLE.
- Timing:
  - start sampled at edge N → busy high for edges N+1 … N+WIDTH.
  - done high for exactly one cycle, WIDTH+1 cycles after the sampling edge; committed digits are visible from that same cycle.
  - Back-to-back conversions: start may be accepted in the cycle after COMMIT.
- start while busy (SHIFT or COMMIT) is ignored: not queued, and the captured value is unchanged.
- Committed digits change only in COMMIT. The display never shows a partial conversion; the previous value stays on the display throughout SHIFT.
- Scan:
  - Free-running counter 0 … SCAN_DIV-1, independent of conversion state.
  - On wrap, scan index advances 0 → 1 → 2 → 3 → 0.
  - digit_sel and data are registered and update on the same edge, one cycle after the index changes. They are never mutually inconsistent.
- Leading-zero blanking: when blank_lz = 1, digit k (k ≥ 1) outputs 8'h0F if it and all higher digits are 0.
- Overflow: all four digits show 8'h0F regardless of blank_lz. overflow stays high until the next COMMIT with an in-range value.
- Boundaries:
  - 9999 is in range and displays 9,9,9,9.
  - 10000 and anything up to 2^WIDTH-1 are overflow.
  - 0 displays 0,0,0,0, or blank,blank,blank,0 with blank_lz = 1.
- Reset mid-conversion aborts immediately: state = IDLE, no done pulse, committed digits and overflow cleared.

Test Plan:
- Reset asserted 2 cycles → data = 8'h00, digit_sel = 4'b0001, busy = 0, done = 0, overflow = 0. Scan then cycles with data = 8'h00 on every digit.
- start with balance = 1234 → busy for 14 cycles, done pulse at cycle 15. Scan shows digit_sel 0001/0010/0100/1000 with data 04/03/02/01, each held 16 cycles.
- balance = 0 with blank_lz = 1 → data = 00 on digit 0 and 0F on digits 1–3. balance = 105 → 05, 00, 01, 0F (interior zero kept).
- balance = 9999 → 09 on all digits, overflow = 0. balance = 10000 → 0F on all digits, overflow = 1. Then balance = 42 → overflow = 0, digits 02, 04, 00, 00.
- start asserted again 5 cycles into a conversion of 1234, with balance = 7777 → ignored. done still at cycle 15, result 1234, only one done pulse.
- Reset asserted at cycle 7 of a conversion → no done pulse, digits = 0, busy = 0 next cycle. A fresh start with 500 converts normally.
